// File: rtl/vdp_arb_pkg.sv
// Shared types and helpers for the super-res VRAM arbiter.
// - slot_owner_t : who owns the current 4-clock VRAM slot
// - ret_entry_t  : one entry of the completion/return pipeline
// - lane_select  : picks byte lane [lane] out of a 32-bit word
// - lane_onehot  : write byte-enable for a byte address
package vdp_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE    = 2'd0,
      OWN_DISPLAY = 2'd1,
      OWN_CPU     = 2'd2,
      OWN_CMD     = 2'd3
   } slot_owner_t;

   localparam int SLOT_LEN  = 4;
   localparam int SLOT_BITS = $clog2(SLOT_LEN);

   typedef struct packed {
      logic        valid;
      slot_owner_t owner;
      logic [1:0]  lane;
      logic        is_read;
   } ret_entry_t;

   function automatic logic [7:0] lane_select(input logic [31:0] word, input logic [1:0] lane);
      return word[8*lane +: 8];
   endfunction

   function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
      return 4'b0001 << lane;
   endfunction

endpackage

// File: rtl/vdp_arb_return_pipe.sv
// Completion pipeline for cpu/cmd accesses.
// Every issued cpu/cmd access enters stage 0. Writes complete out of stage 0
// (one clock after issue); reads ride to stage READ_LATENCY-1 and complete
// there, taking their byte from mem_rdata in that same cycle.
// Ports:
//   clk, reset                     - clock, synchronous active-high reset
//   issue_valid/owner/lane/read    - access issued this cycle
//   mem_rdata                      - read data from the SDRAM controller
//   cpu_ack/cpu_rdata              - CPU completion pulse and held read byte
//   cmd_ack/cmd_rdata              - command-engine completion and read byte
module vdp_arb_return_pipe
   import vdp_arb_pkg::*;
#(
   parameter int READ_LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        issue_valid,
   input  slot_owner_t issue_owner,
   input  logic [1:0]  issue_lane,
   input  logic        issue_read,
   input  logic [31:0] mem_rdata,
   output logic        cpu_ack,
   output logic [7:0]  cpu_rdata,
   output logic        cmd_ack,
   output logic [7:0]  cmd_rdata
);

   ret_entry_t stage [READ_LATENCY];
   logic [7:0] cpu_rdata_q, cmd_rdata_q, rd_byte;
   logic       write_done, read_done, cpu_rd_now, cmd_rd_now;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < READ_LATENCY; k++) stage[k] <= '0;
      end else begin
         stage[0] <= '{valid: issue_valid, owner: issue_owner,
                       lane: issue_lane, is_read: issue_read};
         // Writes have already completed out of stage 0; only reads travel on.
         for (int k = 1; k < READ_LATENCY; k++) begin
            stage[k]       <= stage[k-1];
            stage[k].valid <= stage[k-1].valid & stage[k-1].is_read;
         end
      end
   end

   always_comb begin
      write_done = stage[0].valid && !stage[0].is_read;
      read_done  = stage[READ_LATENCY-1].valid && stage[READ_LATENCY-1].is_read;
      rd_byte    = lane_select(mem_rdata, stage[READ_LATENCY-1].lane);
      cpu_rd_now = read_done && (stage[READ_LATENCY-1].owner == OWN_CPU);
      cmd_rd_now = read_done && (stage[READ_LATENCY-1].owner == OWN_CMD);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_rdata_q <= '0;
         cmd_rdata_q <= '0;
      end else begin
         if (cpu_rd_now) cpu_rdata_q <= rd_byte;
         if (cmd_rd_now) cmd_rdata_q <= rd_byte;
      end
   end

   // The read byte is visible in the ack cycle itself, then held.
   always_comb begin
      cpu_ack   = !reset && ((write_done && stage[0].owner == OWN_CPU) || cpu_rd_now);
      cmd_ack   = !reset && ((write_done && stage[0].owner == OWN_CMD) || cmd_rd_now);
      cpu_rdata = reset ? 8'h00 : (cpu_rd_now ? rd_byte : cpu_rdata_q);
      cmd_rdata = reset ? 8'h00 : (cmd_rd_now ? rd_byte : cmd_rdata_q);
   end

endmodule

// File: rtl/vdp_super_vram_arbiter.sv
// Shares the single 32-bit VRAM/SDRAM port between display fetch, CPU,
// command engine and refresh using 4-clock slots aligned to cx[1:0]==0.
// Handshake: a requester raises req (with wr/addr/wdata stable) and holds it
// until its one-cycle ack; a request rising in a decision cycle is eligible
// immediately; dropping req after grant does not cancel the access.
// Ports:
//   clk, reset                   - clock, synchronous active-high reset
//   vdp_super, super_res_drawing - display fetch enable / window
//   cx, display_addr             - pixel column, next display word address
//   cpu_* / cmd_*                - byte-wide request ports
//   mem_*                        - command strobe and data to SDRAM controller
//   slot_owner                   - 0 none, 1 display, 2 cpu, 3 cmd
module vdp_super_vram_arbiter
   import vdp_arb_pkg::*;
#(
   parameter int READ_LATENCY = 2,
   parameter int REFRESH_X    = 720
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        vdp_super,
   input  logic        super_res_drawing,
   input  logic [9:0]  cx,
   input  logic [17:0] display_addr,
   input  logic        cpu_req,
   input  logic        cpu_wr,
   input  logic [19:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_ack,
   output logic [7:0]  cpu_rdata,
   input  logic        cmd_req,
   input  logic        cmd_wr,
   input  logic [19:0] cmd_addr,
   input  logic [7:0]  cmd_wdata,
   output logic        cmd_ack,
   output logic [7:0]  cmd_rdata,
   output logic        mem_valid,
   output logic        mem_refresh,
   output logic        mem_wr,
   output logic [17:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  slot_owner
);

   localparam logic [9:0] REFRESH_CX = 10'(REFRESH_X);

   logic        decision, refresh_slot, cpu_elig, cmd_elig, cpu_pend, cmd_pend;
   logic        issue_valid, issue_read;
   logic [1:0]  issue_lane;
   slot_owner_t grant, owner_q, rr_last;

   assign decision = (cx[SLOT_BITS-1:0] == '0) && !reset;
   // A requester with an access in flight sits out until its ack.
   assign cpu_elig = cpu_req && !cpu_pend;
   assign cmd_elig = cmd_req && !cmd_pend;

   always_comb begin
      grant        = OWN_NONE;
      refresh_slot = 1'b0;
      if (decision) begin
         if (cx == REFRESH_CX)                     refresh_slot = 1'b1;
         else if (vdp_super && super_res_drawing)  grant = OWN_DISPLAY;
         else if (cpu_elig && (!cmd_elig || rr_last == OWN_CMD)) grant = OWN_CPU;
         else if (cmd_elig)                        grant = OWN_CMD;
      end
   end

   always_comb begin
      mem_valid   = refresh_slot || (grant != OWN_NONE);
      mem_refresh = refresh_slot;
      mem_wr      = 1'b0;
      mem_addr    = '0;
      mem_be      = '0;
      mem_wdata   = '0;
      issue_valid = 1'b0;
      issue_read  = 1'b0;
      issue_lane  = '0;
      case (grant)
         OWN_DISPLAY: begin
            mem_addr = display_addr;
            mem_be   = 4'hF;
         end
         OWN_CPU: begin
            mem_wr      = cpu_wr;
            mem_addr    = cpu_addr[19:2];
            mem_be      = cpu_wr ? lane_onehot(cpu_addr[1:0]) : 4'hF;
            mem_wdata   = cpu_wr ? {4{cpu_wdata}} : 32'h0;
            issue_valid = 1'b1;
            issue_read  = !cpu_wr;
            issue_lane  = cpu_addr[1:0];
         end
         OWN_CMD: begin
            mem_wr      = cmd_wr;
            mem_addr    = cmd_addr[19:2];
            mem_be      = cmd_wr ? lane_onehot(cmd_addr[1:0]) : 4'hF;
            mem_wdata   = cmd_wr ? {4{cmd_wdata}} : 32'h0;
            issue_valid = 1'b1;
            issue_read  = !cmd_wr;
            issue_lane  = cmd_addr[1:0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q  <= OWN_NONE;
         rr_last  <= OWN_CMD;
         cpu_pend <= 1'b0;
         cmd_pend <= 1'b0;
      end else begin
         if (decision) owner_q <= grant;
         if (grant == OWN_CPU || grant == OWN_CMD) rr_last <= grant;
         if (grant == OWN_CPU)  cpu_pend <= 1'b1;
         else if (cpu_ack)      cpu_pend <= 1'b0;
         if (grant == OWN_CMD)  cmd_pend <= 1'b1;
         else if (cmd_ack)      cmd_pend <= 1'b0;
      end
   end

   assign slot_owner = reset ? OWN_NONE : (decision ? grant : owner_q);

   vdp_arb_return_pipe #(.READ_LATENCY(READ_LATENCY)) u_ret (
      .clk         (clk),
      .reset       (reset),
      .issue_valid (issue_valid),
      .issue_owner (grant),
      .issue_lane  (issue_lane),
      .issue_read  (issue_read),
      .mem_rdata   (mem_rdata),
      .cpu_ack     (cpu_ack),
      .cpu_rdata   (cpu_rdata),
      .cmd_ack     (cmd_ack),
      .cmd_rdata   (cmd_rdata)
   );

endmodule

// File: doc/vdp_super_vram_arbiter.md
Name: vdp_super_vram_arbiter

Overview:
- Shares the single 32-bit VRAM/SDRAM port between four users:
  - the super-res scan-out fetcher;
  - the CPU port;
  - the command engine;
  - SDRAM refresh.
- Time-slices the port into 4-clock slots aligned to cx[1:0]==0.
- Gives display fetch every slot while super_res_drawing is high.
- Outside the drawing window, round-robins CPU and command requests.
- Sits between VDP_SUPER_RES / CPU / command blocks and the SDRAM controller.

Parameters:
- READ_LATENCY, 2: clocks from slot issue to mem_rdata valid; legal range 1..3.
- REFRESH_X, 720: cx value whose slot is forced to refresh on every line.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- vdp_super  in  1  super mode enable; when 0, display never owns a slot.
- super_res_drawing  in  1  display fetch window (from VDP_SUPER_RES).
- cx  in  10  current pixel column.
- display_addr  in  18  word address of the next display fetch.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_wr  in  1  1 = write, 0 = read.
- cpu_addr  in  20  byte address.
- cpu_wdata  in  8  write byte.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  8  read byte; valid with cpu_ack.
- cmd_req, cmd_wr, cmd_addr[19:0], cmd_wdata[7:0], cmd_ack, cmd_rdata[7:0]: same contract as the CPU port, for the command engine.
- mem_valid  out  1  one-cycle command strobe to the SDRAM controller.
- mem_refresh  out  1  refresh command; qualified by mem_valid.
- mem_wr  out  1  write command.
- mem_addr  out  18  word address.
- mem_be  out  4  byte enables for writes.
- mem_wdata  out  32  write data; the byte is replicated on all 4 lanes.
- mem_rdata  in  32  read data from the controller.
- slot_owner  out  2  owner of the current slot: 0 none, 1 display, 2 cpu, 3 cmd.

Behaviour:
- Reset: all outputs 0; rr_last = cmd (so the CPU wins the first tie); the return pipeline is flushed.
  - Reset mid-access abandons the access; no ack is issued for it.
- Slot decision happens only on cycles with cx[1:0]==0, using this priority:
  1. If cx==REFRESH_X: refresh. mem_refresh=1, slot_owner=0, no ack.
  2. Else if vdp_super && super_res_drawing: display. mem_addr=display_addr, read, no ack.
  3. Else if cpu_req or cmd_req: round-robin grant.
     - If only one requester is active, it wins.
     - If both are active, the one not equal to rr_last wins.
     - rr_last updates to the winner.
  4. Else: idle; mem_valid stays 0.
- mem_valid pulses for one clock, in the decision cycle, for every non-idle slot.
- slot_owner holds its value for all 4 cycles of the slot.
- A requester already granted, or awaiting ack, is ineligible until its ack.
  - Each requester has at most one outstanding access.
- Address mapping for cpu/cmd:
  - mem_addr = addr[19:2].
  - Writes: mem_be = onehot(addr[1:0]).
  - Reads: mem_be = 4'b1111.
- Write completion: ack pulses 1 clock after the issue cycle.
- Read completion:
  - ack pulses READ_LATENCY clocks after issue.
  - rdata = mem_rdata byte lane addr[1:0], captured in that same cycle.
  - rdata is held until the next ack on that port.
- Every ack occurs before the next slot decision, because latency is ≤3.
- A request rising in a decision cycle is eligible in that same cycle.
- If req drops before ack, the access still completes and ack still pulses.
- Starvation bound: outside the drawing window and refresh, a waiting requester is served within 2 eligible slots.
- Inside the drawing window, cpu/cmd requests wait with no timeout.
- When vdp_super toggles mid-slot, the current slot completes unchanged; the change takes effect at the next decision.
- cx wrap (frame width to 0) needs no special handling; slots stay aligned to cx[1:0].

Decomposition:
- Package vdp_arb_pkg holds:
  - typedef enum logic[1:0] slot_owner_t {OWN_NONE, OWN_DISPLAY, OWN_CPU, OWN_CMD};
  - the byte-lane select function;
  - constant SLOT_LEN = 4.
- One sub-module, vdp_arb_return_pipe:
  - a READ_LATENCY-deep shift register of {owner, lane, is_read};
  - generates cpu_ack/cmd_ack and captures rdata.

Test Plan:
- cpu_req write, addr 0x00005, data 0xA5, drawing=0, cx=4 → mem_valid at cx=4; mem_addr 0x00001; mem_be 0010; mem_wdata 0xA5A5A5A5; cpu_ack at cx=5.
- cmd_req read, addr 0x00013, mem_rdata 0x11223344 → cmd_ack at issue+2; cmd_rdata 0x11.
- cpu_req and cmd_req held continuously over 4 slots → grants alternate cpu, cmd, cpu, cmd.
- super_res_drawing=1, vdp_super=1, cpu_req high → display owns every slot with mem_addr=display_addr; CPU granted in the first slot after drawing falls.
- cx=720 while drawing=1 and cpu_req=1 → mem_refresh=1, slot_owner=0, no ack; next slot follows normal priority.
- Reset asserted 1 clock after a read issue → no ack; all outputs 0; next grant goes to the CPU on a tie.
